ysyx_23060332_wb_sched: RTL and testbench

// - Write-back scheduler and scoreboard for the NPC integer register file (2R/1W, x0 hard-wired 0).
// - Arbitrates EXU and LSU write-back requests onto the single write port: registered reg_wen/waddr/wdata.
// - Tracks in-flight destination registers per rd.
// - Raises busy flags for IDU source operands so IDU stalls on RAW hazards.

---
 rtl/ysyx_23060332_wb_sched_pkg.sv | 19 +
 rtl/ysyx_23060332_rr_arb2.sv | 42 ++++
 rtl/ysyx_23060332_wb_sched.sv | 128 ++++++++++++
 tb/tb_ysyx_23060332_wb_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060332_wb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060332_wb_sched_pkg
// Brief    : Shared widths and write-back source encoding for the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060332_wb_sched_pkg;

    localparam int c_REG_ADDR_W = 5;
    localparam int c_REG_DATA_W = 32;

    // Grant encoding: also used as the bit index into the one-hot grant vector
    typedef enum logic {
        WB_SRC_EXU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060332_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060332_rr_arb2
// Brief    : Two-way round-robin arbiter, one-hot grant plus last-grant flop.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060332_rr_arb2
    import ysyx_23060332_wb_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    wb_src_e r_last;

    // No grants while in reset so nothing is acknowledged and then dropped
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            if (req == 2'b11) begin
                gnt = (r_last == WB_SRC_LSU) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    // Reset value LSU makes EXU win the first contested cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= WB_SRC_LSU;
        end else if (gnt[1]) begin
            r_last <= WB_SRC_LSU;
        end else if (gnt[0]) begin
            r_last <= WB_SRC_EXU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060332_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060332_wb_sched
// Brief    : Write-back arbiter and per-register pending scoreboard for the
//            integer register file. Optional forwarding: YSYX_23060332_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060332_wb_sched
    import ysyx_23060332_wb_sched_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int PEND_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid,
    input  logic [$clog2(NREG)-1:0] iss_rd,
    output logic                    iss_ready,
    input  logic [$clog2(NREG)-1:0] rs1_addr,
    input  logic [$clog2(NREG)-1:0] rs2_addr,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
`ifdef YSYX_23060332_WB_BYPASS_EN
    output logic                    rs1_fwd,
    output logic                    rs2_fwd,
    output logic [XLEN-1:0]         fwd_data,
`endif
    input  logic                    exu_valid,
    output logic                    exu_ready,
    input  logic [$clog2(NREG)-1:0] exu_rd,
    input  logic [XLEN-1:0]         exu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [$clog2(NREG)-1:0] lsu_rd,
    input  logic [XLEN-1:0]         lsu_data,
    output logic                    reg_wen,
    output logic [$clog2(NREG)-1:0] waddr,
    output logic [XLEN-1:0]         wdata
);

    localparam int AW = $clog2(NREG);

    logic [1:0]        w_gnt;
    logic              w_xfer;
    logic [AW-1:0]     w_sel_rd;
    logic [XLEN-1:0]   w_sel_data;
    logic [NREG-1:0]   w_inc;
    logic [NREG-1:0]   w_dec;
    logic [PEND_W-1:0] r_cnt [NREG];
    logic              w_rs1_pend;
    logic              w_rs2_pend;

    ysyx_23060332_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req ({lsu_valid, exu_valid}),
        .gnt (w_gnt)
    );

    assign exu_ready  = w_gnt[int'(WB_SRC_EXU)];
    assign lsu_ready  = w_gnt[int'(WB_SRC_LSU)];
    assign w_xfer     = |w_gnt;
    assign w_sel_rd   = w_gnt[int'(WB_SRC_LSU)] ? lsu_rd   : exu_rd;
    assign w_sel_data = w_gnt[int'(WB_SRC_LSU)] ? lsu_data : exu_data;

    // The write port drains every cycle; an x0 transfer consumes the slot silently
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_wen <= 1'b0;
            waddr   <= '0;
            wdata   <= '0;
        end else begin
            reg_wen <= w_xfer & (w_sel_rd != '0);
            if (w_xfer) begin
                waddr <= w_sel_rd;
                wdata <= w_sel_data;
            end
        end
    end

    // A write landing this cycle frees a slot, so a saturated rd can still issue
    assign iss_ready = (r_cnt[iss_rd] != '1) | (reg_wen & (waddr == iss_rd));

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (iss_valid && iss_ready && (iss_rd != '0)) begin
            w_inc[iss_rd] = 1'b1;
        end
        if (reg_wen) begin
            w_dec[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        r_cnt[0] <= '0;
        for (int r = 1; r < NREG; r++) begin
            if (rst) begin
                r_cnt[r] <= '0;
            end else if (w_inc[r] && !w_dec[r]) begin
                r_cnt[r] <= r_cnt[r] + 1'b1;
            end else if (w_dec[r] && !w_inc[r]) begin
                r_cnt[r] <= r_cnt[r] - 1'b1;
            end
        end
    end

    assign w_rs1_pend = (rs1_addr != '0) & (r_cnt[rs1_addr] != '0);
    assign w_rs2_pend = (rs2_addr != '0) & (r_cnt[rs2_addr] != '0);

`ifdef YSYX_23060332_WB_BYPASS_EN
    // The last outstanding write is on the port now: hand it over instead of stalling
    assign rs1_fwd  = reg_wen & (waddr == rs1_addr) & (r_cnt[rs1_addr] == PEND_W'(1));
    assign rs2_fwd  = reg_wen & (waddr == rs2_addr) & (r_cnt[rs2_addr] == PEND_W'(1));
    assign fwd_data = wdata;
    assign rs1_busy = w_rs1_pend & ~rs1_fwd;
    assign rs2_busy = w_rs2_pend & ~rs2_fwd;
`else
    assign rs1_busy = w_rs1_pend;
    assign rs2_busy = w_rs2_pend;
`endif

    a_no_underflow : assert property (@(posedge clk) disable iff (rst)
        reg_wen |-> (r_cnt[waddr] != '0));

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060332_wb_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060332_wb_sched
// Brief    : Randomized scoreboard bench for the write-back scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060332_wb_sched;

    localparam int PEND_MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        iss_ready;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy, rs2_busy;
    logic        exu_valid = 1'b0, lsu_valid = 1'b0;
    logic        exu_ready, lsu_ready;
    logic [4:0]  exu_rd = '0, lsu_rd = '0;
    logic [31:0] exu_data = '0, lsu_data = '0;
    logic        reg_wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef YSYX_23060332_WB_BYPASS_EN
    logic        rs1_fwd, rs2_fwd;
    logic [31:0] fwd_data;
`endif

    ysyx_23060332_wb_sched dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
`ifdef YSYX_23060332_WB_BYPASS_EN
        .rs1_fwd   (rs1_fwd),
        .rs2_fwd   (rs2_fwd),
        .fwd_data  (fwd_data),
`endif
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_rd    (exu_rd),
        .exu_data  (exu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .reg_wen   (reg_wen),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // Reference state: outstanding writes per register and who was served last
    int  cnt [32];
    bit  last_lsu = 1'b1;
    bit  wb_pend  = 1'b0;
    int  wb_addr  = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every write seen on the port must be the oldest expected one, on time
    initial begin
        forever begin
            @(negedge clk);
            if (reg_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_reg_wen", 32'(reg_wen), 32'h0);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    chk("wb_cycle", 32'(cyc), 32'(e.cyc));
                    chk("waddr", 32'(waddr), 32'(e.addr));
                    chk("wdata", wdata, e.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                wb_t e;
                e = exp_q.pop_front();
                chk("missing_reg_wen", 32'(reg_wen), 32'h1);
            end
        end
    end

    task automatic step(input bit rs, input bit iv, input int ird,
                        input bit ev, input int erd, input logic [31:0] ed,
                        input bit lv, input int lrd, input logic [31:0] ld,
                        input int a1, input int a2,
                        output bit iacc, output bit eacc, output bit lacc);
        bit ge, gl, exp_ir;
        int r;
        logic [31:0] d;
        @(negedge clk);
        rst = rs; iss_valid = iv; iss_rd = ird[4:0];
        exu_valid = ev; exu_rd = erd[4:0]; exu_data = ed;
        lsu_valid = lv; lsu_rd = lrd[4:0]; lsu_data = ld;
        rs1_addr = a1[4:0]; rs2_addr = a2[4:0];
        #1;
        ge = 1'b0; gl = 1'b0;
        if (!rs) begin
            if (ev && lv) begin
                ge = last_lsu;
                gl = !last_lsu;
            end else begin
                ge = ev;
                gl = lv;
            end
        end
        chk("exu_ready", 32'(exu_ready), 32'(ge));
        chk("lsu_ready", 32'(lsu_ready), 32'(gl));
        exp_ir = (cnt[ird] != PEND_MAX) || (wb_pend && wb_addr == ird);
        chk("iss_ready", 32'(iss_ready), 32'(exp_ir));
        chk("rs1_busy", 32'(rs1_busy), 32'(a1 != 0 && cnt[a1] != 0));
        chk("rs2_busy", 32'(rs2_busy), 32'(a2 != 0 && cnt[a2] != 0));
        iacc = !rs && iv && exp_ir;
        eacc = ge;
        lacc = gl;
        if (rs) begin
            foreach (cnt[i]) cnt[i] = 0;
            last_lsu = 1'b1;
            wb_pend  = 1'b0;
            exp_q.delete();
        end else begin
            if (wb_pend) cnt[wb_addr]--;
            if (iacc && ird != 0) cnt[ird]++;
            wb_pend = 1'b0;
            if (ge || gl) begin
                last_lsu = gl;
                r = gl ? lrd : erd;
                d = gl ? ld : ed;
                if (r != 0) begin
                    exp_q.push_back('{cyc + 1, r, d});
                    wb_pend = 1'b1;
                    wb_addr = r;
                end
            end
        end
    endtask

    bit ia, ea, la;

    task automatic idle(input int a1, input int a2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, a1, a2, ia, ea, la);
    endtask

    task automatic issue(input int rd, input int a1);
        step(0, 1, rd, 0, 0, 0, 0, 0, 0, a1, 0, ia, ea, la);
    endtask

    int  owed [32];
    bit  rs, iv, ev, lv, eh, lh;
    int  ird, erd, lrd;
    logic [31:0] ed, ld;

    initial begin
        foreach (cnt[i]) cnt[i] = 0;
        step(1, 0, 0, 1, 2, 32'h1, 1, 3, 32'h2, 0, 0, ia, ea, la);
        step(1, 1, 4, 1, 2, 32'h1, 1, 3, 32'h2, 4, 0, ia, ea, la);
        chk("rst_reg_wen", 32'(reg_wen), 32'h0);
        chk("rst_waddr", 32'(waddr), 32'h0);
        chk("rst_wdata", wdata, 32'h0);

        issue(5, 5);
        step(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, ia, ea, la);
        idle(5, 0);
        idle(5, 0);

        issue(3, 0); issue(4, 0); issue(3, 0); issue(4, 0);
        for (int k = 0; k < 4; k++)
            step(0, 0, 0, 1, 3, 32'h300 + k, 1, 4, 32'h400 + k, 3, 4, ia, ea, la);
        idle(3, 4);

        issue(7, 7);
        idle(7, 0); idle(7, 0);
        step(0, 0, 0, 0, 0, 0, 1, 7, 32'h77, 7, 0, ia, ea, la);
        idle(7, 0); idle(7, 0);

        issue(9, 9); issue(9, 9); issue(9, 9);
        step(0, 1, 9, 1, 9, 32'h9001, 0, 0, 0, 9, 0, ia, ea, la);
        issue(9, 9);
        for (int k = 0; k < 3; k++)
            step(0, 0, 0, 1, 9, 32'h9100 + k, 0, 0, 0, 9, 0, ia, ea, la);
        idle(9, 0); idle(9, 0);

        step(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, ia, ea, la);
        idle(0, 0); idle(0, 0);

        issue(2, 2); issue(2, 2);
        step(1, 0, 0, 1, 2, 32'h2222, 0, 0, 0, 2, 2, ia, ea, la);
        step(0, 0, 2, 0, 0, 0, 0, 0, 0, 2, 2, ia, ea, la);
        chk("post_rst_reg_wen", 32'(reg_wen), 32'h0);

        // Random phase: write-backs only target registers with an unclaimed issue
        foreach (owed[i]) owed[i] = 0;
        eh = 1'b0; lh = 1'b0; ev = 1'b0; lv = 1'b0;
        erd = 0; lrd = 0; ed = '0; ld = '0;
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom_range(0, 199) == 0);
            if (!eh) begin
                ev  = 1'($urandom_range(0, 1));
                erd = $urandom_range(0, 7);
                ed  = $urandom;
                if (ev) begin
                    if (erd != 0 && owed[erd] > 0) owed[erd]--;
                    else erd = 0;
                end
            end
            if (!lh) begin
                lv  = 1'($urandom_range(0, 1));
                lrd = $urandom_range(0, 7);
                ld  = $urandom;
                if (lv) begin
                    if (lrd != 0 && owed[lrd] > 0) owed[lrd]--;
                    else lrd = 0;
                end
            end
            iv  = 1'($urandom_range(0, 1));
            ird = $urandom_range(0, 7);
            step(rs, iv, ird, ev, erd, ed, lv, lrd, ld,
                 $urandom_range(0, 7), $urandom_range(0, 7), ia, ea, la);
            if (rs) begin
                foreach (owed[i]) owed[i] = 0;
                eh = 1'b0;
                lh = 1'b0;
            end else begin
                eh = ev && !ea;
                lh = lv && !la;
                if (ia && ird != 0) owed[ird]++;
            end
        end

        idle(0, 0); idle(0, 0); idle(0, 0);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
